// File: rtl/fmap_collector.sv
// Collects one OUT_W x OUT_H feature map from the conv pixel stream, holds it until released,
// and serves 1-cycle random-access reads. Optional write-path ReLU under FMAP_COLLECTOR_RELU_EN.
module fmap_collector #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_W      = 24,
  parameter int OUT_H      = 24,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  frame_release,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  frame_done,
  output logic                  full,
  output logic                  overflow
);
  localparam int DEPTH = OUT_W * OUT_H;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_COLLECT, S_FULL} state_t;

  state_t                  state_q;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    frame_done_q, full_q, overflow_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept, last_px, wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  // A release in FULL re-arms in the same cycle, so a coincident pixel becomes pixel 0.
  assign accept  = valid_in && ((state_q == S_COLLECT) || frame_release);
  assign last_px = (col_q == CW'(OUT_W - 1)) && (row_q == RW'(OUT_H - 1));
  assign wr_en   = accept && !rst;
  assign wr_addr = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(OUT_W) + ADDR_WIDTH'(col_q);

`ifdef FMAP_COLLECTOR_RELU_EN
  assign wr_data = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
  assign wr_data = data_in;
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == CW'(OUT_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(OUT_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_COLLECT;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= 1'b0;
      case (state_q)
        S_COLLECT: begin
          if (accept && last_px) begin
            state_q      <= S_FULL;
            full_q       <= 1'b1;
            frame_done_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (frame_release) begin
            state_q <= S_COLLECT;
            full_q  <= 1'b0;
          end else if (valid_in) begin
            overflow_q <= 1'b1;
          end
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[MAW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (rd_en) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= (int'(rd_addr) < DEPTH) ? mem[rd_addr[MAW-1:0]] : '0;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign frame_done = frame_done_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_fmap_collector.sv
// Bench for fmap_collector at 4x4: directed frames, release/overflow/reset cases and read corners,
// checked every cycle against a pixel-count model plus literal expectations.
module tb_fmap_collector;
  localparam int DW = 24;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 10;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          frame_release = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, frame_done, full, overflow;

  fmap_collector #(.DATA_WIDTH(DW), .OUT_W(W), .OUT_H(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .frame_release(frame_release), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
    .full(full), .overflow(overflow));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int fd_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef FMAP_COLLECTOR_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  // Model: a frame is simply N accepted pixels in arrival order.
  logic [DW-1:0] mmem [N];
  int            m_cnt = 0;
  bit            m_hold = 0, m_fd = 0, m_ovf = 0, m_rv = 0;
  logic [DW-1:0] m_rd = '0;

  initial for (int i = 0; i < N; i++) mmem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_hold = 0; m_fd = 0; m_ovf = 0; m_rv = 0; m_rd = '0;
    end else begin
      if (rd_en) begin
        m_rv = 1;
        m_rd = (int'(rd_addr) < N) ? mmem[int'(rd_addr)] : '0;
      end else m_rv = 0;
      m_fd = 0;
      if (m_hold && frame_release) m_hold = 0;
      if (valid_in) begin
        if (m_hold) m_ovf = 1;
        else begin
          mmem[m_cnt] = stored(data_in);
          m_cnt++;
          if (m_cnt == N) begin m_cnt = 0; m_hold = 1; m_fd = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (chk_en) begin
      chk("m_frame_done", {31'b0, frame_done}, {31'b0, m_fd});
      chk("m_full", {31'b0, full}, {31'b0, m_hold});
      chk("m_overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("m_rd_valid", {31'b0, rd_valid}, {31'b0, m_rv});
      if (m_rv) chk("m_rd_data", {8'b0, rd_data}, {8'b0, m_rd});
    end
  end

  task automatic idle();
    @(negedge clk);
    valid_in = 0; rd_en = 0; frame_release = 0;
  endtask

  task automatic px(input logic [DW-1:0] d);
    @(negedge clk);
    valid_in = 1; data_in = d; rd_en = 0; frame_release = 0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] exp, input string name);
    @(negedge clk);
    valid_in = 0; frame_release = 0; rd_en = 1; rd_addr = AW'(a);
    @(negedge clk);
    rd_en = 0;
    chk({name, "_vld"}, {31'b0, rd_valid}, 32'd1);
    chk(name, {8'b0, rd_data}, {8'b0, exp});
  endtask

  task automatic release1();
    @(negedge clk);
    valid_in = 0; rd_en = 0; frame_release = 1;
    @(negedge clk);
    frame_release = 0;
  endtask

  initial begin
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_fd", {31'b0, frame_done}, 32'd0);
    chk("rst_rv", {31'b0, rd_valid}, 32'd0);
    chk("rst_rd", {8'b0, rd_data}, 32'd0);

    // Back-to-back frame, data = index.
    for (int i = 0; i < N; i++) px(DW'(i));
    idle();
    chk("t1_fd", {31'b0, frame_done}, 32'd1);
    chk("t1_full", {31'b0, full}, 32'd1);
    idle();
    chk("t1_fd_low", {31'b0, frame_done}, 32'd0);
    for (int i = 0; i < N; i++) rd(i, DW'(i), "t1_rd");

    // Release and pixel together; pixel 5 written while addr 5 is read.
    @(negedge clk);
    frame_release = 1; valid_in = 1; data_in = 24'hABCDEF;
    @(negedge clk);
    frame_release = 0; valid_in = 0;
    chk("t3_full", {31'b0, full}, 32'd0);
    chk("t3_ovf", {31'b0, overflow}, 32'd0);
    rd(0, 24'hABCDEF, "t3_addr0");
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      if (i == 6) chk("rbw_old", {8'b0, rd_data}, 32'd5);
      valid_in = 1; data_in = DW'(32'h50 + i);
      rd_en = (i == 5); rd_addr = AW'(5);
    end
    idle();
    chk("t3_fd", {31'b0, frame_done}, 32'd1);
    rd(5, 24'h55, "rbw_new");
    rd(20, 24'h0, "oob_rd");
    chk("t3_fd_cnt", fd_cnt, 32'd2);

    // Toggled valid, then 3 pixels dropped while full.
    release1();
    for (int i = 0; i < N; i++) begin
      px(DW'(32'h200 + i));
      idle();
    end
    for (int k = 0; k < 3; k++) px(DW'(32'hEEE0 + k));
    idle();
    chk("t2_ovf", {31'b0, overflow}, 32'd1);
    chk("t2_full", {31'b0, full}, 32'd1);
    for (int i = 0; i < N; i++) rd(i, DW'(32'h200 + i), "t2_rd");
    chk("t2_fd_cnt", fd_cnt, 32'd3);

    // Reset mid-frame discards progress.
    release1();
    for (int i = 0; i < 7; i++) px(DW'(32'h70 + i));
    idle();
    rd(3, 24'h73, "t4_pre");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t4_rst_rd", {8'b0, rd_data}, 32'd0);
    chk("t4_rst_fd", {31'b0, frame_done}, 32'd0);
    chk("t4_rst_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < N; i++) px(DW'(100 + i));
    idle();
    chk("t4_fd", {31'b0, frame_done}, 32'd1);
    rd(0, 24'd100, "t4_addr0");
    rd(15, 24'd115, "t4_addr15");
    chk("t4_fd_cnt", fd_cnt, 32'd4);

    // Negative pixel handling.
    release1();
    px(24'hFFFFFF);
    px(24'h000010);
    idle();
`ifdef FMAP_COLLECTOR_RELU_EN
    rd(0, 24'h000000, "neg_store");
`else
    rd(0, 24'hFFFFFF, "neg_store");
`endif
    rd(1, 24'h000010, "pos_store");

    repeat (3) idle();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
